// File: rtl/bus_rr_sched.sv
// bus_rr_sched: round-robin scheduler sharing one packet bus between drvrs source FIFOs.
// A granted source is popped, its destination ID decoded from the top byte, and the
// packet is pushed to the destination FIFO (or every FIFO for broadcast) once all
// targeted FIFOs have room.
// Build option: define BUS_RR_SCHED_BCAST_SELF_EN to include the source in its own broadcast.

module bus_rr_sched #(
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [drvrs-1:0]         pndng,
    input  logic [drvrs*pckg_sz-1:0] D_pop,
    output logic [drvrs-1:0]         pop,
    input  logic [drvrs-1:0]         full,
    output logic [drvrs-1:0]         push,
    output logic [pckg_sz-1:0]       D_push,
    output logic [3:0]               grant_id,
    output logic                     busy,
    output logic [15:0]              drop_cnt
);

    localparam int         IW       = (drvrs > 1) ? $clog2(drvrs) : 1;
    localparam logic [7:0] DRVRS_ID = 8'(drvrs);
    localparam logic [3:0] LAST_ID  = 4'(drvrs - 1);

    typedef enum logic [1:0] {
        IDLE,
        POP,
        DELIVER
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [pckg_sz-1:0] pkt;
    logic [pckg_sz-1:0] pkt_nx;
    logic [drvrs-1:0]   targets;
    logic [drvrs-1:0]   targets_nx;
    logic [drvrs-1:0]   pop_nx;
    logic [drvrs-1:0]   push_nx;
    logic [pckg_sz-1:0] d_push_nx;
    logic [3:0]         grant_nx;
    logic               busy_nx;
    logic [15:0]        drop_nx;
    logic [pckg_sz-1:0] head [drvrs];
    logic [IW-1:0]      cand;
    logic [IW-1:0]      g_sel;
    logic               found;
    logic [7:0]         id;
    logic [drvrs-1:0]   self_mask;

    // Split the flattened head-packet bus into one word per source.
    for (genvar i = 0; i < drvrs; i++) begin : g_head
        assign head[i] = D_pop[i*pckg_sz +: pckg_sz];
    end

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        state_nx   = state;
        pop_nx     = '0;
        push_nx    = '0;
        d_push_nx  = D_push;
        grant_nx   = grant_id;
        drop_nx    = drop_cnt;
        pkt_nx     = pkt;
        targets_nx = targets;
        found      = 1'b0;
        cand       = '0;
        g_sel      = '0;
        id         = pkt[pckg_sz-1 -: 8];
        self_mask  = '0;

        case (state)
            IDLE: begin
                for (int k = 1; k <= drvrs; k++) begin
                    cand = IW'((int'(grant_id) + k) % drvrs);
                    if (!found && pndng[cand]) begin
                        found = 1'b1;
                        g_sel = cand;
                    end
                end
                if (found) begin
                    pop_nx[g_sel] = 1'b1;
                    grant_nx      = 4'(g_sel);
                    pkt_nx        = head[g_sel];
                    state_nx      = POP;
                end
            end

            POP: begin
                if (id == broadcast) begin
`ifdef BUS_RR_SCHED_BCAST_SELF_EN
                    self_mask = '0;
`else
                    self_mask[grant_id[IW-1:0]] = 1'b1;
`endif
                    targets_nx = ~self_mask;
                    state_nx   = DELIVER;
                end else if (id < DRVRS_ID) begin
                    targets_nx               = '0;
                    targets_nx[id[IW-1:0]]   = 1'b1;
                    state_nx                 = DELIVER;
                end else begin
                    if (drop_cnt != 16'hFFFF) begin
                        drop_nx = drop_cnt + 16'd1;
                    end
                    state_nx = IDLE;
                end
            end

            DELIVER: begin
                if ((targets & full) == '0) begin
                    push_nx   = targets;
                    d_push_nx = pkt;
                    state_nx  = IDLE;
                end
            end

            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx != IDLE);
    end

    // State and registered-output flops, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pop      <= '0;
            push     <= '0;
            D_push   <= '0;
            grant_id <= LAST_ID;
            busy     <= 1'b0;
            drop_cnt <= '0;
            pkt      <= '0;
            targets  <= '0;
        end else begin
            state    <= state_nx;
            pop      <= pop_nx;
            push     <= push_nx;
            D_push   <= d_push_nx;
            grant_id <= grant_nx;
            busy     <= busy_nx;
            drop_cnt <= drop_nx;
            pkt      <= pkt_nx;
            targets  <= targets_nx;
        end
    end

endmodule

// File: tb/tb_bus_rr_sched.sv
// tb_bus_rr_sched: scoreboard bench for bus_rr_sched with four agents and 16-bit packets.
// Source FIFOs are modelled as small first-word-fall-through arrays; expected pushes are
// queued when a packet is loaded and compared when the scheduler drives the bus.

module tb_bus_rr_sched;

    localparam int N = 4;
    localparam int W = 16;

`ifdef BUS_RR_SCHED_BCAST_SELF_EN
    localparam logic [3:0] BCAST_MASK = 4'b1111;
`else
    localparam logic [3:0] BCAST_MASK = 4'b1011;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   pndng;
    logic [N*W-1:0] D_pop;
    logic [N-1:0]   pop;
    logic [N-1:0]   full;
    logic [N-1:0]   push;
    logic [W-1:0]   D_push;
    logic [3:0]     grant_id;
    logic           busy;
    logic [15:0]    drop_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];

    logic [15:0] mem [N][16];
    logic [3:0]  wr_ptr [N];
    logic [3:0]  rd_ptr [N] = '{default: 4'd0};

    bus_rr_sched #(
        .drvrs    (N),
        .pckg_sz  (W),
        .broadcast(8'hFF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .pndng   (pndng),
        .D_pop   (D_pop),
        .pop     (pop),
        .full    (full),
        .push    (push),
        .D_push  (D_push),
        .grant_id(grant_id),
        .busy    (busy),
        .drop_cnt(drop_cnt)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Source FIFO model: head word and non-empty flag follow the read pointer.
    for (genvar i = 0; i < N; i++) begin : g_src
        assign pndng[i]          = (wr_ptr[i] != rd_ptr[i]);
        assign D_pop[i*W +: W]   = mem[i][rd_ptr[i]];
    end

    // Advance source read pointers on pop strobes and count cycles.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < N; i++) begin
            if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 4'd1;
        end
    end

    task automatic load(input int src, input logic [15:0] pkt, input logic [3:0] mask, input bit expect_push);
        mem[src][wr_ptr[src]] = pkt;
        wr_ptr[src] = wr_ptr[src] + 4'd1;
        if (expect_push) sb.push_back('{mask: mask, data: pkt});
    endtask

    task automatic sb_next(output exp_t e);
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end else begin
            e.mask = 'x;
            e.data = 'x;
        end
    endtask

    task automatic wait_pop(output bit ok);
        int k;
        ok = 1'b0;
        k  = 0;
        while (!ok && k < 12) begin
            @(negedge clk);
            if (pop != '0) ok = 1'b1;
            k++;
        end
    endtask

    task automatic wait_push(output bit ok);
        int k;
        ok = 1'b0;
        k  = 0;
        while (!ok && k < 20) begin
            @(negedge clk);
            if (push != '0) ok = 1'b1;
            k++;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (pop !== 4'b0000 || push !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_strobes got pop=%b push=%b exp pop=0000 push=0000", pop, push);
        end
        checks++;
        if (D_push !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_dpush got=%h exp=0000", D_push);
        end
        checks++;
        if (grant_id !== 4'd3) begin
            errors++;
            $display("[TB] FAIL reset_grant got=%0d exp=3", grant_id);
        end
        checks++;
        if (busy !== 1'b0 || drop_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_busy_drop got busy=%b drop=%0d exp busy=0 drop=0", busy, drop_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_unicast();
        exp_t e;
        load(0, 16'h0234, 4'b0100, 1'b1);
        @(negedge clk);
        checks++;
        if (pop !== 4'b0001 || grant_id !== 4'd0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL uni_pop got pop=%b grant=%0d busy=%b exp pop=0001 grant=0 busy=1", pop, grant_id, busy);
        end
        @(negedge clk);
        checks++;
        if (pop !== 4'b0000 || push !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL uni_gap got pop=%b push=%b exp 0000/0000", pop, push);
        end
        @(negedge clk);
        sb_next(e);
        checks++;
        if (push !== e.mask || D_push !== e.data) begin
            errors++;
            $display("[TB] FAIL uni_push got push=%b data=%h exp push=%b data=%h", push, D_push, e.mask, e.data);
        end
        @(negedge clk);
        checks++;
        if (push !== 4'b0000 || D_push !== 16'h0234 || busy !== 1'b0 || drop_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL uni_after got push=%b data=%h busy=%b drop=%0d exp 0000/0234/0/0",
                     push, D_push, busy, drop_cnt);
        end
    endtask

    task automatic test_round_robin();
        exp_t       e;
        bit         ok;
        int         last_cyc;
        logic [3:0] ep;
        apply_reset();
        load(0, 16'h0110, 4'b0010, 1'b1);
        load(1, 16'h0221, 4'b0100, 1'b1);
        load(2, 16'h0332, 4'b1000, 1'b1);
        load(3, 16'h0043, 4'b0001, 1'b1);
        load(0, 16'h0214, 4'b0100, 1'b1);
        last_cyc = 0;
        for (int n = 0; n < 5; n++) begin
            ep = 4'b0001 << (n % 4);
            wait_pop(ok);
            checks++;
            if (!ok || pop !== ep || grant_id !== 4'(n % 4)) begin
                errors++;
                $display("[TB] FAIL rr_grant%0d got pop=%b grant=%0d exp pop=%b grant=%0d", n, pop, grant_id, ep, n % 4);
            end
            if (n > 0) begin
                checks++;
                if (cyc - last_cyc != 3) begin
                    errors++;
                    $display("[TB] FAIL rr_interval%0d got=%0d exp=3", n, cyc - last_cyc);
                end
            end
            last_cyc = cyc;
            @(negedge clk);
            checks++;
            if (pop !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL rr_pop_width%0d got=%b exp=0000", n, pop);
            end
            @(negedge clk);
            sb_next(e);
            checks++;
            if (push !== e.mask || D_push !== e.data) begin
                errors++;
                $display("[TB] FAIL rr_push%0d got push=%b data=%h exp push=%b data=%h", n, push, D_push, e.mask, e.data);
            end
        end
    endtask

    task automatic test_broadcast();
        exp_t e;
        bit   ok;
        load(2, 16'hFFAA, BCAST_MASK, 1'b1);
        wait_pop(ok);
        checks++;
        if (!ok || pop !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL bcast_pop got=%b exp=0100", pop);
        end
        wait_push(ok);
        sb_next(e);
        checks++;
        if (!ok || push !== e.mask || D_push !== e.data) begin
            errors++;
            $display("[TB] FAIL bcast_push got push=%b data=%h exp push=%b data=%h", push, D_push, e.mask, e.data);
        end
    endtask

    task automatic test_back_pressure();
        exp_t e;
        bit   ok;
        full = 4'b1000;
        load(0, 16'h0355, 4'b1000, 1'b1);
        wait_pop(ok);
        checks++;
        if (!ok || pop !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL bp_pop got=%b exp=0001", pop);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (push !== 4'b0000 || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL bp_stall%0d got push=%b busy=%b exp push=0000 busy=1", k, push, busy);
            end
        end
        full = 4'b0000;
        @(negedge clk);
        sb_next(e);
        checks++;
        if (push !== e.mask || D_push !== e.data) begin
            errors++;
            $display("[TB] FAIL bp_release got push=%b data=%h exp push=%b data=%h", push, D_push, e.mask, e.data);
        end
    endtask

    task automatic test_invalid_id();
        exp_t e;
        bit   ok;
        load(1, 16'h07C3, 4'b0000, 1'b0);
        load(2, 16'h0011, 4'b0001, 1'b1);
        wait_pop(ok);
        checks++;
        if (!ok || pop !== 4'b0010 || grant_id !== 4'd1) begin
            errors++;
            $display("[TB] FAIL inv_pop got pop=%b grant=%0d exp pop=0010 grant=1", pop, grant_id);
        end
        @(negedge clk);
        checks++;
        if (pop !== 4'b0000 || push !== 4'b0000 || drop_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL inv_drop got pop=%b push=%b drop=%0d exp 0000/0000/1", pop, push, drop_cnt);
        end
        @(negedge clk);
        checks++;
        if (pop !== 4'b0100 || grant_id !== 4'd2 || push !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL inv_next got pop=%b grant=%0d push=%b exp 0100/2/0000", pop, grant_id, push);
        end
        wait_push(ok);
        sb_next(e);
        checks++;
        if (!ok || push !== e.mask || D_push !== e.data) begin
            errors++;
            $display("[TB] FAIL inv_next_push got push=%b data=%h exp push=%b data=%h", push, D_push, e.mask, e.data);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   ok;
        full = 4'b0001;
        load(3, 16'h0077, 4'b0001, 1'b0);
        wait_pop(ok);
        checks++;
        if (!ok || pop !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL rst_mid_pop got=%b exp=1000", pop);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_mid_stalled got busy=%b exp=1", busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (push !== 4'b0000 || busy !== 1'b0 || drop_cnt !== 16'd0 || grant_id !== 4'd3 || pop !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL rst_mid_async got push=%b busy=%b drop=%0d grant=%0d pop=%b exp 0000/0/0/3/0000",
                     push, busy, drop_cnt, grant_id, pop);
        end
        @(negedge clk);
        reset = 1'b0;
        full  = 4'b0000;
        load(2, 16'h0099, 4'b0001, 1'b1);
        load(1, 16'h0388, 4'b1000, 1'b1);
        sb.push_back(sb.pop_front());
        wait_pop(ok);
        checks++;
        if (!ok || pop !== 4'b0010 || grant_id !== 4'd1) begin
            errors++;
            $display("[TB] FAIL rst_mid_first got pop=%b grant=%0d exp pop=0010 grant=1", pop, grant_id);
        end
        wait_push(ok);
        sb_next(e);
        checks++;
        if (!ok || push !== e.mask || D_push !== e.data) begin
            errors++;
            $display("[TB] FAIL rst_mid_push1 got push=%b data=%h exp push=%b data=%h", push, D_push, e.mask, e.data);
        end
        wait_pop(ok);
        checks++;
        if (!ok || pop !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL rst_mid_second got pop=%b exp=0100", pop);
        end
        wait_push(ok);
        sb_next(e);
        checks++;
        if (!ok || push !== e.mask || D_push !== e.data) begin
            errors++;
            $display("[TB] FAIL rst_mid_push2 got push=%b data=%h exp push=%b data=%h", push, D_push, e.mask, e.data);
        end
    endtask

    // Test sequence: each scenario drives its own stimulus and checks inline.
    initial begin
        reset = 1'b1;
        full  = 4'b0000;
        for (int i = 0; i < N; i++) begin
            wr_ptr[i] = 4'd0;
            for (int j = 0; j < 16; j++) mem[i][j] = 16'h0000;
        end
        test_reset();
        test_unicast();
        test_round_robin();
        test_broadcast();
        test_back_pressure();
        test_invalid_id();
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0 || pndng !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL drain got sb=%0d pndng=%b exp sb=0 pndng=0000", sb.size(), pndng);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_rr_sched.md
Name: bus_rr_sched

Overview:
Round-robin scheduler that shares the single packet bus between `drvrs` source FIFOs.
- Each cycle it picks one pending source, pops its head packet and decodes the destination ID from the packet's top byte.
- It then pushes the packet to the destination FIFO, or to all FIFOs for broadcast, once every targeted FIFO has room.
- It sits between the per-driver input FIFOs (pndng/pop/D_pop) and the per-driver output FIFOs (push/D_push/full).

Parameters:
- drvrs, 4, number of bus agents; legal range 2..16.
- pckg_sz, 16, packet width in bits; must be >= 9. Bits [pckg_sz-1:pckg_sz-8] hold the destination ID.
- broadcast, 8'hFF, destination ID that selects all agents.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- pndng, input, drvrs: bit i high = source FIFO i is non-empty.
- D_pop, input, drvrs*pckg_sz: flattened head packets; slice i = [i*pckg_sz +: pckg_sz]. Source FIFOs are first-word-fall-through, so the slice is valid whenever pndng[i] is high.
- pop, output, drvrs: one-hot, one-cycle pop strobe to the source FIFO.
- full, input, drvrs: bit i high = destination FIFO i cannot accept a push.
- push, output, drvrs: push strobe(s) to destination FIFO(s).
- D_push, output, pckg_sz: shared bus data, valid while any push bit is high.
- grant_id, output, 4: index of the last granted source.
- busy, output, 1: high in any state other than IDLE.
- drop_cnt, output, 16: count of packets dropped for an invalid ID.

Behaviour:
- All outputs are registered.
- Reset values: pop=0, push=0, D_push=0, grant_id=drvrs-1 (so the first grant goes to 0), busy=0, drop_cnt=0, state=IDLE.
- State IDLE:
  - If pndng != 0, grant the first set bit searching upward from grant_id+1, wrapping modulo drvrs.
  - Register pop[g]=1, grant_id=g, latch pkt=D_pop slice g, and go to POP.
  - If pndng == 0, stay in IDLE.
- State POP:
  - pop returns to 0, so pop is high for exactly one cycle.
  - Decode id = pkt[pckg_sz-1 -: 8].
  - If id == broadcast: targets = all agents except the source g.
  - Else if id < drvrs: targets = one-hot(id). id == g is legal (self-send).
  - Else: increment drop_cnt (saturating at 16'hFFFF) and go to IDLE with no push.
  - For legal targets, go to DELIVER.
- State DELIVER:
  - Wait while (targets & full) != 0; push stays 0 while waiting.
  - When all targets are non-full, register push=targets and D_push=pkt for exactly one cycle, then go to IDLE.
  - No partial broadcast delivery: it is all-or-wait.
- Latency, no back-pressure: pndng seen at cycle 0, pop at cycle 1, push at cycle 3. Minimum grant interval is 3 cycles.
- D_push holds its last value after push drops.
- pndng changes during POP or DELIVER do not affect the current transfer. The next arbitration happens only in IDLE.
- Single requester: it is re-granted every transfer. Round-robin guarantees that any pending source is served within drvrs grants.
- Reset asserted mid-transfer:
  - All outputs return to reset values immediately (asynchronous).
  - The in-flight packet is lost. It has already been popped and is not re-delivered.
- full asserted indefinitely stalls the scheduler in DELIVER; there is no timeout.

Optional Feature:
- Macro: BUS_RR_SCHED_BCAST_SELF_EN.
- Defined: broadcast targets = all drvrs agents, including the source.
- Undefined (default): the broadcast source is excluded from its own broadcast.
- Ports and timing are otherwise identical in both cases.

Test Plan:
- Unicast: reset, then pndng=0001 with D_pop[0]=16'h0234. Expect pop=0001 at cycle 1 and push=0100 with D_push=16'h0234 at cycle 3. drop_cnt stays 0.
- Round-robin: pndng=1111 held with valid IDs. Expect grants in the order 0,1,2,3,0. Each pop is one cycle and successive pops are 3 cycles apart.
- Broadcast: source 2 sends 16'hFFAA.
  - Default build: push=1011 with D_push=16'hFFAA.
  - With BUS_RR_SCHED_BCAST_SELF_EN defined: push=1111.
- Back-pressure: source 0 sends to ID 3 while full=1000 for 5 cycles. Expect push=0 throughout and busy=1. Push=1000 occurs one cycle after full drops.
- Invalid ID: source 1 sends 16'h07C3. Expect pop asserted, no push, drop_cnt=1. The scheduler returns to IDLE and grants the next requester.
- Reset mid-operation: assert reset during DELIVER. Expect push=0, busy=0, drop_cnt=0 immediately. After release, the first grant goes to the lowest pending index.
